// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with HI/LO registers.
// One radix-2 step per cycle; 32-cycle busy window per MULT/DIV.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  ctl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        res_sel,
    output logic [31:0] res,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  cnt;

    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplier;

    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvsr;

    logic        neg_q;
    logic        neg_r;
    logic        div_zero;

    logic        start_mul;
    logic        start_div;
    logic        is_signed;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        last;

    logic [63:0] acc_nxt;
    logic [63:0] prod_fix;
    logic [32:0] shifted;
    logic        fits;
    logic [31:0] sub;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign start_mul = (ctl == 3'd1) || (ctl == 3'd2);
    assign start_div = (ctl == 3'd3) || (ctl == 3'd4);
    assign is_signed = (ctl == 3'd1) || (ctl == 3'd3);
    assign mag_a     = (is_signed && a[31]) ? (~a + 32'd1) : a;
    assign mag_b     = (is_signed && b[31]) ? (~b + 32'd1) : b;
    assign last      = (cnt == 5'd31);

    assign busy = (state != IDLE);
    assign res  = res_sel ? hi : lo;

    // Shift-add multiply step; the final step feeds the sign fix directly.
    assign acc_nxt  = mplier[0] ? (acc + mcand) : acc;
    assign prod_fix = neg_q ? (~acc_nxt + 64'd1) : acc_nxt;

    // Restoring divide step: remainder fits in 32 bits after each trial.
    assign shifted = {rem, quo[31]};
    assign fits    = (shifted >= {1'b0, dvsr});
    assign sub     = shifted[31:0] - dvsr;
    assign rem_nxt = fits ? sub : shifted[31:0];
    assign quo_nxt = {quo[30:0], fits};
    // Divide-by-zero keeps the all-ones quotient unsigned; rem is |a| re-signed.
    assign quo_fix = (neg_q && !div_zero) ? (~quo_nxt + 32'd1) : quo_nxt;
    assign rem_fix = neg_r ? (~rem_nxt + 32'd1) : rem_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!flush) begin
                    if (start_mul) begin
                        state_nxt = MUL;
                    end else if (start_div) begin
                        state_nxt = DIV;
                    end
                end
            end
            MUL, DIV: begin
                if (flush || last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi       <= 32'd0;
            lo       <= 32'd0;
            cnt      <= 5'd0;
            acc      <= 64'd0;
            mcand    <= 64'd0;
            mplier   <= 32'd0;
            rem      <= 32'd0;
            quo      <= 32'd0;
            dvsr     <= 32'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!flush) begin
                        if (ctl == 3'd5) begin
                            hi <= a;
                        end
                        if (ctl == 3'd6) begin
                            lo <= a;
                        end
                        if (start_mul) begin
                            acc      <= 64'd0;
                            mcand    <= {32'd0, mag_a};
                            mplier   <= mag_b;
                            cnt      <= 5'd0;
                            neg_q    <= is_signed && (a[31] ^ b[31]);
                            neg_r    <= 1'b0;
                            div_zero <= 1'b0;
                        end
                        if (start_div) begin
                            rem      <= 32'd0;
                            quo      <= mag_a;
                            dvsr     <= mag_b;
                            cnt      <= 5'd0;
                            neg_q    <= is_signed && (a[31] ^ b[31]);
                            neg_r    <= is_signed && a[31];
                            div_zero <= (b == 32'd0);
                        end
                    end
                end
                MUL: begin
                    if (!flush) begin
                        acc    <= acc_nxt;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 5'd1;
                        if (last) begin
                            hi <= prod_fix[63:32];
                            lo <= prod_fix[31:0];
                        end
                    end
                end
                DIV: begin
                    if (!flush) begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        cnt <= cnt + 5'd1;
                        if (last) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end
                    end
                end
                default: begin
                    cnt <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic [2:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        res_sel;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    int n_cmp;
    int n_err;

    muldiv_unit dut (
        .clk     (clk),
        .rst     (rst),
        .ctl     (ctl),
        .a       (a),
        .b       (b),
        .flush   (flush),
        .res_sel (res_sel),
        .res     (res),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue an op, count busy cycles (bounded), then check HI/LO.
    task automatic run_op(input string tag, input logic [2:0] c,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el);
        int n;
        ctl = c;
        a   = x;
        b   = y;
        tick();
        ctl = 3'd0;
        n   = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_cycles"}, n, 32);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
    endtask

    initial begin
        int n;
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b1;
        ctl     = 3'd0;
        a       = 32'd0;
        b       = 32'd0;
        flush   = 1'b0;
        res_sel = 1'b0;
        #12;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // MULTU with an MTLO attempt mid-operation
        ctl = 3'd2;
        a   = 32'hFFFF_FFFF;
        b   = 32'd2;
        tick();
        ctl = 3'd0;
        chk("multu_busy_e0", {31'd0, busy}, 32'd1);
        n = 0;
        while (busy && n < 100) begin
            if (n == 9) begin
                ctl = 3'd6;
                a   = 32'hDEAD_BEEF;
            end else begin
                ctl = 3'd0;
            end
            if (n == 16) begin
                res_sel = 1'b0;
                #1;
                chk("multu_res_old", res, 32'd0);
                chk("multu_hi_old", hi, 32'd0);
            end
            tick();
            n++;
        end
        ctl = 3'd0;
        chk("multu_cycles", n, 32);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        run_op("mult_neg", 3'd1, 32'hFFFF_FFFF, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mult_min", 3'd1, 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, 32'h0000_0000);
        run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_7_2", 3'd4, 32'd7, 32'd2, 32'd1, 32'd3);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h8000_0000);
        run_op("divu_z", 3'd4, 32'h1234_5678, 32'd0,
               32'h1234_5678, 32'hFFFF_FFFF);
        run_op("div_z", 3'd3, 32'hFFFF_FFFB, 32'd0,
               32'hFFFF_FFFB, 32'hFFFF_FFFF);

        // MTHI then MTLO back to back
        ctl = 3'd5;
        a   = 32'hAAAA_5555;
        tick();
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        ctl = 3'd6;
        a   = 32'h0000_1234;
        tick();
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        ctl     = 3'd0;
        res_sel = 1'b1;
        #1;
        chk("res_hi", res, 32'hAAAA_5555);
        res_sel = 1'b0;
        #1;
        chk("res_lo", res, 32'h0000_1234);

        // flush in IDLE blocks ctl
        flush = 1'b1;
        ctl   = 3'd5;
        a     = 32'h5A5A_5A5A;
        tick();
        flush = 1'b0;
        ctl   = 3'd0;
        chk("idle_flush_hi", hi, 32'hAAAA_5555);

        // flush a MULT at iteration 15
        ctl = 3'd1;
        a   = 32'd3;
        b   = 32'd5;
        tick();
        ctl = 3'd0;
        for (int i = 0; i < 14; i++) tick();
        chk("flush_pre_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_hi", hi, 32'hAAAA_5555);
        chk("flush_lo", lo, 32'h0000_1234);
        tick();
        chk("flush_busy2", {31'd0, busy}, 32'd0);

        // async reset mid-MULT
        ctl = 3'd1;
        a   = 32'd9;
        b   = 32'd9;
        tick();
        ctl = 3'd0;
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        run_op("multu_after", 3'd2, 32'h0001_0000, 32'h0001_0003,
               32'h0000_0001, 32'h0003_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative integer multiply/divide unit with architectural HI/LO registers.
- Sits in the execute stage, directly downstream of the register file. It consumes the rs/rt operands delivered by the register file's read ports (after forwarding muxes).
- Returns HI or LO to the writeback path for MFHI/MFLO.
- Raises a busy/stall flag that the pipeline controller uses to hold the PC (keep) and pipeline registers.

Parameters:
- none. Control encodings are fixed, as listed under `ctl`.

Ports:
- clk       in   1   rising-edge clock
- rst       in   1   asynchronous, active-high reset
- ctl       in   3   operation: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP
- a         in   32  rs operand (dividend / multiplicand / MTHI-MTLO source)
- b         in   32  rt operand (divisor / multiplier)
- flush     in   1   abort any in-flight operation (exception/IRQ taken)
- res_sel   in   1   0 = output LO, 1 = output HI
- res       out  32  combinational: res_sel ? hi : lo
- hi        out  32  HI register
- lo        out  32  LO register
- busy      out  1   operation in progress; pipeline must stall MULT/DIV/MFHI/MFLO/MTHI/MTLO while high

Behaviour:
- Reset (async, rst=1): hi=0, lo=0, busy=0, state=IDLE, iteration counter=0, internal accumulators cleared. This holds even when rst asserts mid-operation; the operation is lost.
- States: IDLE, MUL, DIV.
  - IDLE->MUL on ctl in {1,2}.
  - IDLE->DIV on ctl in {3,4}.
  - MUL/DIV->IDLE after iteration 32 or on flush.
- Accept: `ctl` is sampled only when busy=0 (IDLE). Non-NOP ctl while busy=1 is ignored; no queuing.
- MTHI/MTLO: at the accepting edge hi<=a (or lo<=a). Single cycle, busy stays 0.
- MULT/DIV latency:
  - Accept at edge E0. Operands are latched at E0.
  - busy=1 from just after E0 through E32.
  - One radix-2 iteration per edge E1..E32; 5-bit counter runs 0..31.
  - At E32: hi/lo written, busy returns to 0, state=IDLE.
  - Total busy window is exactly 32 cycles.
  - hi/lo hold their old values until E32.
  - A new op may be accepted at E33.
- Signed ops (MULT/DIV):
  - Operands are converted to magnitudes at E0, the unsigned core runs, and the sign is fixed at E32.
  - Product is negated (64-bit two's complement) when a[31]^b[31].
  - Quotient is negated when a[31]^b[31].
  - Remainder takes the sign of a.
- Unsigned ops (MULTU/DIVU): no sign handling. 64-bit product {hi,lo}; lo=quotient, hi=remainder.
- Multiply core: shift-add. A 64-bit accumulator adds the shifted multiplicand on each multiplier LSB.
- Divide core: restoring. A 33-bit trial subtract is done per iteration, shifting one quotient bit into lo.
- Divide by zero (b=0), both DIV and DIVU: no sign correction applied. Result is lo=32'hFFFFFFFF, hi=a (the raw input a).
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of the magnitude path; no special case.
- flush:
  - Takes priority over iteration and over completion at E32.
  - The in-flight op is dropped, hi/lo are left unchanged, and busy=0 on the next cycle.
  - If flush=1 while in IDLE, any ctl in that cycle is ignored.
- res is purely combinational from hi/lo/res_sel. A read while busy=1 returns the old value.

Test Plan:
- MULTU a=0xFFFFFFFF b=2 -> after exactly 32 busy cycles: hi=0x00000001, lo=0xFFFFFFFE. A MTLO issued on cycle 10 is ignored.
- MULT a=0xFFFFFFFF (-1) b=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE. Also MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x12345678 b=0 -> lo=0xFFFFFFFF, hi=0x12345678. DIV a=-5 b=0 -> lo=0xFFFFFFFF, hi=0xFFFFFFFB.
- MTHI 0xAAAA5555, then MTLO 0x1234 on consecutive cycles -> busy never set. res_sel=1 gives 0xAAAA5555; res_sel=0 gives 0x1234.
- Interruptions on a MULT in flight:
  - flush at iteration 15 -> busy=0 next cycle, hi/lo keep the pre-op values.
  - rst pulse mid-op (async, between edges) -> hi=lo=0 and busy=0 immediately.
  - A new MULTU is then accepted and completes correctly.
